// File: rtl/tow_press_reader_if.sv
// Press-latch bus between the Tug-of-War player latches/game control and the press reader.
// The master drives start and the latched flags; the slave (reader) drives clears, moves and status.
interface tow_press_reader_if #(
  parameter int POS_W = 4
);
  logic             start;
  logic             q_left;
  logic             q_right;
  logic             clr_left;
  logic             clr_right;
  logic             move_left;
  logic             move_right;
  logic [POS_W-1:0] pos;
  logic [1:0]       winner;
  logic             busy;

  modport master (
    output start, q_left, q_right,
    input  clr_left, clr_right, move_left, move_right, pos, winner, busy
  );

  modport slave (
    input  start, q_left, q_right,
    output clr_left, clr_right, move_left, move_right, pos, winner, busy
  );
endinterface

// File: rtl/tow_press_reader.sv
// Tug-of-War press reader: arbitrates latched presses, steps the rope, clears latches, holds off.
// Optional macro TOW_TIE_ALTERNATE_EN: ties move the side named by an alternating priority bit.
//
// state   | meaning
// IDLE    | after reset, waiting for start; both latches held cleared
// ARMED   | round running, accepting the next press
// HOLDOFF | press accepted; serviced latch(es) held cleared while counter runs
// DONE    | rope reached an end; winner latched until start
module tow_press_reader #(
  parameter int POS_MAX        = 8,
  parameter int POS_W          = 4,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input logic              clk,
  input logic              rst,
  tow_press_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF, DONE} state_t;

  localparam logic [POS_W-1:0] CENTRE = POS_W'(POS_MAX / 2);
  localparam logic [POS_W-1:0] PMAX   = POS_W'(POS_MAX);
  localparam logic [CNT_W-1:0] HOLD   = CNT_W'(HOLDOFF_CYCLES);

  state_t           state;
  logic [POS_W-1:0] pos_q;
  logic [1:0]       winner_q;
  logic             mvl_q, mvr_q, clrl_q, clrr_q, busy_q;
  logic [CNT_W-1:0] cnt;
  logic             press_l, press_r;
  logic [POS_W-1:0] pos_nxt;
`ifdef TOW_TIE_ALTERNATE_EN
  logic             tie_pri;  // 0 favours left, 1 favours right
`endif

  always_comb begin
    press_l = bus.q_left & ~bus.q_right;
    press_r = bus.q_right & ~bus.q_left;
`ifdef TOW_TIE_ALTERNATE_EN
    if (bus.q_left && bus.q_right) begin
      press_l = ~tie_pri;
      press_r = tie_pri;
    end
`endif
    pos_nxt = pos_q;
    if (press_l)      pos_nxt = pos_q - POS_W'(1);
    else if (press_r) pos_nxt = pos_q + POS_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pos_q    <= CENTRE;
      winner_q <= 2'b00;
      mvl_q    <= 1'b0;
      mvr_q    <= 1'b0;
      clrl_q   <= 1'b1;
      clrr_q   <= 1'b1;
      busy_q   <= 1'b0;
      cnt      <= '0;
`ifdef TOW_TIE_ALTERNATE_EN
      tie_pri  <= 1'b0;
`endif
    end else begin
      mvl_q <= 1'b0;
      mvr_q <= 1'b0;
      if (bus.start) begin
        // clears pulse for one cycle to flush any stale latch before arming
        state    <= ARMED;
        pos_q    <= CENTRE;
        winner_q <= 2'b00;
        clrl_q   <= 1'b1;
        clrr_q   <= 1'b1;
        busy_q   <= 1'b1;
        cnt      <= '0;
`ifdef TOW_TIE_ALTERNATE_EN
        tie_pri  <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            clrl_q <= 1'b1;
            clrr_q <= 1'b1;
            busy_q <= 1'b0;
          end
          ARMED: begin
            if (bus.q_left || bus.q_right) begin
              pos_q <= pos_nxt;
              mvl_q <= press_l;
              mvr_q <= press_r;
`ifdef TOW_TIE_ALTERNATE_EN
              if (bus.q_left && bus.q_right) tie_pri <= ~tie_pri;
`endif
              if ((press_l && pos_nxt == '0) || (press_r && pos_nxt == PMAX)) begin
                state    <= DONE;
                winner_q <= press_l ? 2'b01 : 2'b10;
                clrl_q   <= 1'b1;
                clrr_q   <= 1'b1;
                busy_q   <= 1'b0;
                cnt      <= '0;
              end else begin
                state  <= HOLDOFF;
                clrl_q <= bus.q_left;
                clrr_q <= bus.q_right;
                cnt    <= HOLD;
              end
            end else begin
              clrl_q <= 1'b0;
              clrr_q <= 1'b0;
            end
          end
          HOLDOFF: begin
            // counter runs HOLD..0, giving HOLD+1 cycles of clear
            if (cnt == '0) begin
              state  <= ARMED;
              clrl_q <= 1'b0;
              clrr_q <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          DONE: begin
            clrl_q <= 1'b1;
            clrr_q <= 1'b1;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.pos        = pos_q;
  assign bus.winner     = winner_q;
  assign bus.move_left  = mvl_q;
  assign bus.move_right = mvr_q;
  assign bus.clr_left   = clrl_q;
  assign bus.clr_right  = clrr_q;
  assign bus.busy       = busy_q;

endmodule
